// File: rtl/wdt_service_ctrl_if.sv
// Register bus and watchdog outputs of the watchdog service front-end.
// The firmware side (or a bench) uses master; the controller uses slave.
interface wdt_service_ctrl_if;
  logic        reg_wr;
  logic        reg_rd;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        wdt_kick;
  logic        wdt_irq;

  modport master (
    output reg_wr, reg_rd, reg_addr, reg_wdata,
    input  reg_rdata, wdt_kick, wdt_irq
  );

  modport slave (
    input  reg_wr, reg_rd, reg_addr, reg_wdata,
    output reg_rdata, wdt_kick, wdt_irq
  );
endinterface

// File: rtl/wdt_service_ctrl.sv
// Watchdog service front-end: auto-kicks the clock/reset manager until
// firmware enables the watchdog, then kicks only on a correct two-write key
// sequence inside the service window. Any fault stops kicking for good, so
// the manager's own watchdog resets the system.
//
// state    | meaning
// DISABLED | watchdog off, periodic auto-kick every AUTO_KICK_CYCLES
// IDLE     | enabled, waiting for the arm key 0x5555
// ARMED    | arm key seen, waiting for the service key 0xAAAA
// FAULT    | terminal; no kicks, count frozen, only warn W1C honoured
module wdt_service_ctrl #(
  parameter int CNT_W            = 32,
  parameter int TIMEOUT_CYCLES   = 1000000,
  parameter int WARN_CYCLES      = 100000,
  parameter int WINDOW_MIN       = 250000,
  parameter int AUTO_KICK_CYCLES = 50000
) (
  input  logic                 clk_sys,
  input  logic                 rst_sys_n,
  wdt_service_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_ARMED    = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] AUTO_LAST   = CNT_W'(AUTO_KICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_AT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WARN_AT     = CNT_W'(TIMEOUT_CYCLES - WARN_CYCLES);
  localparam logic [CNT_W-1:0] WIN_MIN     = CNT_W'(WINDOW_MIN);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [31:0]      KEY_ARM     = 32'h0000_5555;
  localparam logic [31:0]      KEY_SERVICE = 32'h0000_AAAA;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             enable;
  logic             win_en;
  logic             irq_en;
  logic             warn_pend;
  logic             fault;
  logic             key_armed;
  logic             kick_q;
  logic [31:0]      rdata_q;

  logic wr_ctrl;
  logic wr_key;
  logic wr_status;

  assign wr_ctrl   = bus.reg_wr && (bus.reg_addr == 2'd0);
  assign wr_key    = bus.reg_wr && (bus.reg_addr == 2'd1);
  assign wr_status = bus.reg_wr && (bus.reg_addr == 2'd2);

  // Outputs: kick and read data are registered, the interrupt is a
  // combinational function of registered flags.
  assign bus.wdt_kick  = kick_q;
  assign bus.reg_rdata = rdata_q;
  assign bus.wdt_irq   = (warn_pend | fault) & irq_en;

  // Sequencer, elapsed counter, configuration and read-back register.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state     <= ST_DISABLED;
      count     <= '0;
      enable    <= 1'b0;
      win_en    <= 1'b0;
      irq_en    <= 1'b0;
      warn_pend <= 1'b0;
      fault     <= 1'b0;
      key_armed <= 1'b0;
      kick_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      kick_q <= 1'b0;

      if (bus.reg_rd) begin
        case (bus.reg_addr)
          2'd0:    rdata_q <= {29'd0, irq_en, win_en, enable};
          2'd1:    rdata_q <= '0;
          2'd2:    rdata_q <= {24'd0, 2'b00, state, key_armed, fault, warn_pend, enable};
          default: rdata_q <= 32'(count);
        endcase
      end

      // W1C is honoured in every state; a warning raised on the same edge wins.
      if (wr_status && bus.reg_wdata[1]) warn_pend <= 1'b0;

      case (state)
        ST_DISABLED: begin
          if (count == AUTO_LAST) begin
            kick_q <= 1'b1;
            count  <= '0;
          end else begin
            count <= count + 1'b1;
          end
          if (wr_ctrl) begin
            win_en <= bus.reg_wdata[1];
            irq_en <= bus.reg_wdata[2];
            if (bus.reg_wdata[0]) begin
              enable <= 1'b1;
              state  <= ST_IDLE;
              count  <= '0;
            end
          end
        end

        ST_IDLE, ST_ARMED: begin
          // Timeout takes priority over any key write on the same edge.
          if (count == TIMEOUT_AT) begin
            state <= ST_FAULT;
            fault <= 1'b1;
          end else begin
            if (count != CNT_MAX) count <= count + 1'b1;
            if (count == WARN_AT) warn_pend <= 1'b1;
            if (wr_key) begin
              if (state == ST_IDLE && bus.reg_wdata == KEY_ARM) begin
                state     <= ST_ARMED;
                key_armed <= 1'b1;
              end else if (state == ST_ARMED && bus.reg_wdata == KEY_SERVICE &&
                           !(win_en && count < WIN_MIN)) begin
                kick_q    <= 1'b1;
                count     <= '0;
                warn_pend <= 1'b0;
                key_armed <= 1'b0;
                state     <= ST_IDLE;
              end else begin
                // Wrong key or early service: freeze the count where it stood.
                state <= ST_FAULT;
                fault <= 1'b1;
                count <= count;
              end
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wdt_service_ctrl.sv
// Directed scenarios with randomized timing, bad keys and background reads,
// checked cycle by cycle against a timestamp-based behavioural model.
module tb_wdt_service_ctrl;
  localparam int TIMEOUT   = 100;
  localparam int WARN      = 20;
  localparam int WMIN      = 30;
  localparam int AUTO_KICK = 40;
  localparam int MGR_WDT   = 100;

  localparam int S_DIS   = 0;
  localparam int S_IDLE  = 1;
  localparam int S_ARMED = 2;
  localparam int S_FAULT = 3;

  logic clk_sys   = 1'b0;
  logic rst_sys_n = 1'b0;

  wdt_service_ctrl_if bus ();

  wdt_service_ctrl #(
    .CNT_W            (32),
    .TIMEOUT_CYCLES   (TIMEOUT),
    .WARN_CYCLES      (WARN),
    .WINDOW_MIN       (WMIN),
    .AUTO_KICK_CYCLES (AUTO_KICK)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .bus       (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int tests = 0;
  int fails = 0;

  // Model: elapsed count is (now - base) except in FAULT, where it is frozen.
  int          m_now, m_base, m_frozen, m_state;
  bit          m_en, m_win, m_irqen, m_warn, m_fault, m_armed, m_kick;
  logic [31:0] m_rdata;

  // Manager watchdog, fed by the kicks the DUT actually produces.
  int mgr_idle;
  bit mgr_fired;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_now = 0; m_base = 0; m_frozen = 0; m_state = S_DIS;
    m_en = 0; m_win = 0; m_irqen = 0; m_warn = 0; m_fault = 0; m_armed = 0;
    m_kick = 0; m_rdata = '0;
    mgr_idle = 0; mgr_fired = 0;
  endtask

  task automatic model_update(input bit wr, input bit rd, input logic [1:0] a, input logic [31:0] d);
    int  cnt;
    bit  go_fault;
    cnt = (m_state == S_FAULT) ? m_frozen : (m_now - m_base);
    go_fault = 0;
    m_kick = 0;
    if (rd) begin
      case (a)
        2'd0: m_rdata = {29'd0, m_irqen, m_win, m_en};
        2'd1: m_rdata = '0;
        2'd2: m_rdata = 32'(m_state * 16 + m_armed * 8 + m_fault * 4 + m_warn * 2 + m_en);
        default: m_rdata = 32'(cnt);
      endcase
    end
    if (wr && a == 2'd2 && d[1]) m_warn = 0;
    if (m_state == S_DIS) begin
      if (cnt == AUTO_KICK - 1) begin
        m_kick = 1;
        m_base = m_now + 1;
      end
      if (wr && a == 2'd0) begin
        m_win = d[1];
        m_irqen = d[2];
        if (d[0]) begin
          m_en = 1;
          m_state = S_IDLE;
          m_base = m_now + 1;
        end
      end
    end else if (m_state != S_FAULT) begin
      if (cnt == TIMEOUT) go_fault = 1;
      else begin
        if (cnt == TIMEOUT - WARN) m_warn = 1;
        if (wr && a == 2'd1) begin
          if (m_state == S_IDLE) begin
            if (d == 32'h5555) begin m_state = S_ARMED; m_armed = 1; end
            else go_fault = 1;
          end else if (d == 32'hAAAA && !(m_win && cnt < WMIN)) begin
            m_kick = 1; m_base = m_now + 1; m_warn = 0; m_armed = 0; m_state = S_IDLE;
          end else go_fault = 1;
        end
      end
      if (go_fault) begin
        m_state = S_FAULT; m_fault = 1; m_frozen = cnt;
      end
    end
    m_now++;
  endtask

  // One clock: step the model with the inputs seen at the edge, then compare.
  task automatic cycle();
    bit          wr, rd;
    logic [1:0]  a;
    logic [31:0] d;
    wr = bus.reg_wr; rd = bus.reg_rd; a = bus.reg_addr; d = bus.reg_wdata;
    @(posedge clk_sys);
    model_update(wr, rd, a, d);
    #1;
    check("kick", {31'd0, bus.wdt_kick}, {31'd0, m_kick});
    check("irq", {31'd0, bus.wdt_irq}, {31'd0, (m_warn | m_fault) & m_irqen});
    check("rdata", bus.reg_rdata, m_rdata);
    if (bus.wdt_kick) mgr_idle = 0;
    else mgr_idle++;
    if (mgr_idle >= MGR_WDT) mgr_fired = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) begin
        bus.reg_rd = 1'b1;
        bus.reg_addr = 2'($urandom_range(3));
      end
      cycle();
      bus.reg_rd = 1'b0;
    end
  endtask

  task automatic write(input logic [1:0] a, input logic [31:0] d);
    bus.reg_wr = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
    cycle();
    bus.reg_wr = 1'b0; bus.reg_wdata = $urandom;
  endtask

  task automatic read(input logic [1:0] a, output logic [31:0] v);
    bus.reg_rd = 1'b1; bus.reg_addr = a;
    cycle();
    bus.reg_rd = 1'b0;
    v = bus.reg_rdata;
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst_sys_n = 1'b0;
    bus.reg_wr = 1'b0; bus.reg_rd = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
    model_reset();
    #1;
    check("rst_kick", {31'd0, bus.wdt_kick}, 32'd0);
    check("rst_irq", {31'd0, bus.wdt_irq}, 32'd0);
    check("rst_rdata", bus.reg_rdata, 32'd0);
    @(negedge clk_sys);
    rst_sys_n = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] bad;
    int          nkick, first;

    // 1: auto-kick every 40 cycles while disabled; manager never starves.
    do_reset();
    nkick = 0;
    for (int i = 1; i <= 200; i++) begin
      cycle();
      if (bus.wdt_kick) begin
        nkick++;
        check("auto_kick_phase", 32'(i % AUTO_KICK), 32'd0);
      end
    end
    check("auto_kick_count", 32'(nkick), 32'd5);
    check("auto_mgr_alive", {31'd0, mgr_fired}, 32'd0);

    // 2: legal service after enable.
    do_reset();
    idle($urandom_range(20));
    write(2'd0, 32'h5);
    idle(50);
    write(2'd1, 32'h5555);
    write(2'd1, 32'hAAAA);
    check("svc_kick", {31'd0, bus.wdt_kick}, 32'd1);
    read(2'd3, v);
    check("svc_count_le2", {31'd0, v <= 32'd2}, 32'd1);
    read(2'd2, v);
    check("svc_state_idle", {28'd0, v[7:4]}, 32'd1);

    // 3: service inside the closed window is a violation.
    do_reset();
    write(2'd0, 32'h3);
    idle($urandom_range(5, 20));
    write(2'd1, 32'h5555);
    write(2'd1, 32'hAAAA);
    check("win_no_kick", {31'd0, bus.wdt_kick}, 32'd0);
    read(2'd2, v);
    check("win_status", v, 32'h3D);
    write(2'd1, 32'h5555);
    write(2'd1, 32'hAAAA);
    for (int i = 0; i < 150 && !mgr_fired; i++) cycle();
    check("win_mgr_fired", {31'd0, mgr_fired}, 32'd1);

    // 4: wrong first key faults; later keys are ignored.
    do_reset();
    write(2'd0, 32'h1);
    idle($urandom_range(1, 30));
    bad = $urandom;
    if (bad == 32'h5555) bad = 32'h1234;
    write(2'd1, bad);
    read(2'd2, v);
    check("badkey_status", v, 32'h35);
    write(2'd1, 32'h5555);
    write(2'd1, 32'hAAAA);
    check("badkey_no_kick", {31'd0, bus.wdt_kick}, 32'd0);

    // 5: warning at count 80, W1C, timeout at count 100.
    do_reset();
    idle($urandom_range(10));
    write(2'd0, 32'h5);
    idle(80);
    check("warn_not_early", {31'd0, bus.wdt_irq}, 32'd0);
    cycle();
    check("warn_irq", {31'd0, bus.wdt_irq}, 32'd1);
    write(2'd2, 32'h2);
    check("warn_w1c", {31'd0, bus.wdt_irq}, 32'd0);
    idle(18);
    check("timeout_not_early", {31'd0, bus.wdt_irq}, 32'd0);
    cycle();
    check("timeout_irq", {31'd0, bus.wdt_irq}, 32'd1);
    read(2'd3, v);
    check("timeout_count", v, 32'd100);

    // 6: enable is sticky, config locked; reset from FAULT restarts auto-kick.
    do_reset();
    write(2'd0, 32'h7);
    write(2'd0, 32'h0);
    read(2'd0, v);
    check("lock_ctrl", v, 32'h7);
    write(2'd1, 32'h0BAD);
    read(2'd2, v);
    check("lock_fault_status", v, 32'h35);
    #2;
    rst_sys_n = 1'b0;
    model_reset();
    #1;
    check("midrst_irq", {31'd0, bus.wdt_irq}, 32'd0);
    check("midrst_rdata", bus.reg_rdata, 32'd0);
    check("midrst_kick", {31'd0, bus.wdt_kick}, 32'd0);
    @(negedge clk_sys);
    rst_sys_n = 1'b1;
    first = 0;
    for (int i = 1; i <= 45; i++) begin
      cycle();
      if (bus.wdt_kick && first == 0) first = i;
    end
    check("rst_first_kick", 32'(first), 32'd40);
    read(2'd2, v);
    check("rst_status", v, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
